// File: rtl/three_or_pkg.sv
// Shared defaults and helpers for the three_or registered OR/NOR block.
package three_or_pkg;

    localparam int W_DEF     = 1;
    localparam int SYNC_DEF  = 0;
    localparam int CNT_W_DEF = 8;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/three_or_sync.sv
// Width x stages flop chain used to bring level inputs into the clk domain.
module three_or_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0][W-1:0] chain;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chain <= '0;
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/three_or.sv
// Registered bitwise OR/NOR of three level inputs with optional input
// synchronizers and a saturating rise counter on D[0].
module three_or
    import three_or_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    output logic [W-1:0]     D,
    output logic [W-1:0]     E,
    output logic [CNT_W-1:0] d_rises,
    input  logic             cnt_clr
);

    logic [W-1:0] sync_a, sync_b, sync_c;
    logic [W-1:0] comb;

    three_or_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst(rst), .d(A), .q(sync_a));
    three_or_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst(rst), .d(B), .q(sync_b));
    three_or_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync_c (.clk(clk), .rst(rst), .d(C), .q(sync_c));

    assign comb = sync_a | sync_b | sync_c;

    // The rise is judged against the registered D[0], so the edge that
    // leaves reset only counts if D[0] genuinely goes 0->1.
    always_ff @(posedge clk) begin
        if (rst) begin
            D       <= '0;
            E       <= '1;
            d_rises <= '0;
        end else begin
            D <= comb;
            E <= ~comb;
            if (cnt_clr)
                d_rises <= '0;
            else if (!D[0] && comb[0])
                d_rises <= CNT_W'(sat_inc(32'(d_rises), CNT_W));
        end
    end

endmodule

// File: tb/tb_three_or.sv
// Randomized and directed checks of three_or in four configurations against
// a history-based reference model.
module tb_three_or;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst, cnt_clr;
    logic [3:0] a, b, c;

    logic [0:0] d0, e0, d1, e1, d2, e2;
    logic [3:0] d3, e3;
    logic [7:0] r0, r1, r3;
    logic [1:0] r2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u0: W=1 S=0; u1: W=1 S=2; u2: W=1 S=0 CNT_W=2; u3: W=4 S=0
    three_or #(.W(1), .SYNC_STAGES(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .A(a[0:0]), .B(b[0:0]), .C(c[0:0]), .D(d0), .E(e0), .d_rises(r0), .cnt_clr(cnt_clr));
    three_or #(.W(1), .SYNC_STAGES(2), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .A(a[0:0]), .B(b[0:0]), .C(c[0:0]), .D(d1), .E(e1), .d_rises(r1), .cnt_clr(cnt_clr));
    three_or #(.W(1), .SYNC_STAGES(0), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .A(a[0:0]), .B(b[0:0]), .C(c[0:0]), .D(d2), .E(e2), .d_rises(r2), .cnt_clr(cnt_clr));
    three_or #(.W(4), .SYNC_STAGES(0), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d3), .E(e3), .d_rises(r3), .cnt_clr(cnt_clr));

    function automatic int stg(int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int cmax(int k);
        return (k == 2) ? 3 : 255;
    endfunction

    function automatic logic [3:0] wmask(int k);
        return (k == 3) ? 4'hF : 4'h1;
    endfunction

    function automatic logic [31:0] got_d(int k);
        case (k)
            0: return 32'(d0);
            1: return 32'(d1);
            2: return 32'(d2);
            default: return 32'(d3);
        endcase
    endfunction

    function automatic logic [31:0] got_e(int k);
        case (k)
            0: return 32'(e0);
            1: return 32'(e1);
            2: return 32'(e2);
            default: return 32'(e3);
        endcase
    endfunction

    function automatic logic [31:0] got_r(int k);
        case (k)
            0: return 32'(r0);
            1: return 32'(r1);
            2: return 32'(r2);
            default: return 32'(r3);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-edge history of the ORed inputs, reset and clear.
    // D at edge n is the OR sampled S edges earlier, unless any reset edge
    // fell between that sample and edge n.
    logic [3:0] orh[$];
    bit         rsth[$];
    bit         clrh[$];
    int         cnt_m[N];
    bit         pd[N];

    function automatic logic [3:0] exp_d(int k, int n);
        int s;
        s = stg(k);
        if (n - s < 0) return 4'h0;
        for (int j = n - s; j <= n; j++)
            if (rsth[j]) return 4'h0;
        return orh[n - s] & wmask(k);
    endfunction

    task automatic cycle();
        logic [3:0] ed [N];
        int n;
        @(posedge clk);
        orh.push_back(a | b | c);
        rsth.push_back(rst);
        clrh.push_back(cnt_clr);
        n = orh.size() - 1;
        for (int k = 0; k < N; k++) begin
            ed[k] = exp_d(k, n);
            if (rsth[n] || clrh[n])
                cnt_m[k] = 0;
            else if (ed[k][0] && !pd[k] && cnt_m[k] < cmax(k))
                cnt_m[k] = cnt_m[k] + 1;
            pd[k] = ed[k][0];
        end
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("d%0d", k), got_d(k), 32'(ed[k]));
            chk($sformatf("e%0d", k), got_e(k), 32'(~ed[k] & wmask(k)));
            chk($sformatf("rises%0d", k), got_r(k), 32'(cnt_m[k]));
        end
    endtask

    task automatic set_in(input logic [3:0] na, input logic [3:0] nb, input logic [3:0] nc);
        a = na; b = nb; c = nc;
    endtask

    initial begin
        rst = 1'b1; cnt_clr = 1'b0;
        set_in(4'h0, 4'h0, 4'h0);
        for (int k = 0; k < N; k++) begin cnt_m[k] = 0; pd[k] = 1'b0; end
        repeat (3) cycle();
        chk("rst_d3", 32'(d3), 32'h0);
        chk("rst_e3", 32'(e3), 32'hF);
        chk("rst_cnt", 32'(r0), 32'h0);
        rst = 1'b0;

        // all eight ABC combinations, one cycle each
        for (int v = 0; v < 8; v++) begin
            set_in({3'b0, v[2]}, {3'b0, v[1]}, {3'b0, v[0]});
            cycle();
            chk("sweep_d0", 32'(d0), (v == 0) ? 32'h0 : 32'h1);
        end

        // A/B/C toggling every 100/200/400 ns
        for (int t = 0; t < 80; t++) begin
            set_in({3'b0, 1'((t / 10) % 2)}, {3'b0, 1'((t / 20) % 2)}, {3'b0, 1'((t / 40) % 2)});
            cycle();
        end

        // synchronized path: 0->1 step on A reaches D after three edges
        set_in(4'h0, 4'h0, 4'h0);
        rst = 1'b1; cycle();
        rst = 1'b0; cycle(); cycle();
        set_in(4'h1, 4'h0, 4'h0);
        cycle(); chk("sync_e1", 32'(d1), 32'h0);
        cycle(); chk("sync_e2", 32'(d1), 32'h0);
        cycle(); chk("sync_e3", 32'(d1), 32'h1);
        chk("sync_cnt", 32'(r1), 32'h1);

        // saturation on the 2-bit counter
        set_in(4'h0, 4'h0, 4'h0);
        cnt_clr = 1'b1; cycle();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(4'h1, 4'h0, 4'h0); cycle();
            chk("sat_cnt", 32'(r2), (i < 3) ? 32'(i + 1) : 32'h3);
            set_in(4'h0, 4'h0, 4'h0); cycle();
        end

        // clear wins over a simultaneous rise
        set_in(4'h1, 4'h0, 4'h0); cnt_clr = 1'b1; cycle();
        cnt_clr = 1'b0;
        chk("clr_rise0", 32'(r0), 32'h0);
        chk("clr_rise2", 32'(r2), 32'h0);

        // reset while A is high, then release with A still high
        cycle();
        rst = 1'b1; cycle();
        chk("rst_a_d", 32'(d0), 32'h0);
        chk("rst_a_e", 32'(e0), 32'h1);
        chk("rst_a_cnt", 32'(r0), 32'h0);
        rst = 1'b0; cycle();
        chk("rel_d", 32'(d0), 32'h1);
        chk("rel_cnt", 32'(r0), 32'h1);

        // bitwise merge on the 4-bit instance
        set_in(4'b0001, 4'b0100, 4'b0000); cycle();
        chk("w4_d", 32'(d3), 32'h5);
        chk("w4_e", 32'(e3), 32'hA);

        // random levels with occasional clear and reset
        for (int t = 0; t < 400; t++) begin
            set_in(4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 2) != 0) begin a = 4'h0; b = 4'h0; c = 4'h0; end
            cnt_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
